// File: rtl/day44_dff_pipe.sv
// WIDTH-bit, DEPTH-stage register pipeline with per-stage valid bits, stall, flush and
// a live occupancy count. Data reset is selectable per instance; valid bits always reset.
module day44_dff_pipe #(
   parameter int               WIDTH    = 8,
   parameter int               DEPTH    = 4,
   parameter int               DATA_RST = 1,
   parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en_i,
   input  logic                         flush_i,
   input  logic                         valid_i,
   input  logic [WIDTH-1:0]             d_i,
   output logic [WIDTH-1:0]             q_o,
   output logic                         valid_o,
   output logic [WIDTH*DEPTH-1:0]       taps_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [CW-1:0]    count_q;

   generate
      if (DATA_RST != 0) begin : g_data_rst
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int k = 0; k < DEPTH; k++) stage_q[k] <= RST_VAL;
            end else if (flush_i) begin
               for (int k = 0; k < DEPTH; k++) stage_q[k] <= RST_VAL;
            end else if (en_i) begin
               stage_q[0] <= d_i;
               for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
            end
         end
      end else begin : g_data_norst
         // Reset-free flops: reset only blocks capture, flush leaves data in place.
         always_ff @(posedge clk) begin
            if (!reset && !flush_i && en_i) begin
               stage_q[0] <= d_i;
               for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
      end else if (flush_i) begin
         valid_q <= '0;
      end else if (en_i) begin
         valid_q[0] <= valid_i;
         for (int k = 1; k < DEPTH; k++) valid_q[k] <= valid_q[k-1];
      end
   end

   // Occupancy tracks entry minus exit, so it always equals the popcount of valid_q.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (flush_i) begin
         count_q <= '0;
      end else if (en_i) begin
         count_q <= count_q + CW'(valid_i) - CW'(valid_q[DEPTH-1]);
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_taps
      assign taps_o[k*WIDTH +: WIDTH] = stage_q[k];
   end

   assign q_o     = stage_q[DEPTH-1];
   assign valid_o = valid_q[DEPTH-1];
   assign count_o = count_q;

endmodule

// File: tb/tb_day44_dff_pipe.sv
// Drives a reset-flavour and a no-reset-flavour pipe with shared stimulus and compares
// both against a queue-based model of the stage contents.
module tb_day44_dff_pipe;

   localparam int         WIDTH = 8;
   localparam int         DEPTH = 4;
   localparam logic [7:0] RV    = 8'hA5;

   logic        clk = 1'b0;
   logic        reset;
   logic        en_i, flush_i, valid_i;
   logic [7:0]  d_i;

   logic [7:0]  q_r, q_n;
   logic        valid_r, valid_n;
   logic [31:0] taps_r, taps_n;
   logic [2:0]  count_r, count_n;

   int compared   = 0;
   int mismatched = 0;

   // Model: index 0 is stage 0. known[] marks no-reset data that has been written.
   logic [7:0] mdr[$];
   logic [7:0] mdn[$];
   bit         mv[$];
   bit         mk[$];

   always #5 clk = ~clk;

   day44_dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DATA_RST(1), .RST_VAL(RV)) dut_r (
      .clk(clk), .reset(reset), .en_i(en_i), .flush_i(flush_i), .valid_i(valid_i), .d_i(d_i),
      .q_o(q_r), .valid_o(valid_r), .taps_o(taps_r), .count_o(count_r)
   );

   day44_dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DATA_RST(0), .RST_VAL(RV)) dut_n (
      .clk(clk), .reset(reset), .en_i(en_i), .flush_i(flush_i), .valid_i(valid_i), .d_i(d_i),
      .q_o(q_n), .valid_o(valid_n), .taps_o(taps_n), .count_o(count_n)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      mdr.delete(); mdn.delete(); mv.delete(); mk.delete();
      for (int k = 0; k < DEPTH; k++) begin
         mdr.push_back(RV); mdn.push_back(8'h00); mv.push_back(1'b0); mk.push_back(1'b0);
      end
   endtask

   task automatic modelStep(input bit en, input bit fl, input bit v, input logic [7:0] d);
      if (fl) begin
         foreach (mv[k]) begin
            mv[k]  = 1'b0;
            mdr[k] = RV;
         end
      end else if (en) begin
         mdr.push_front(d); void'(mdr.pop_back());
         mdn.push_front(d); void'(mdn.pop_back());
         mv.push_front(v);  void'(mv.pop_back());
         mk.push_front(1'b1); void'(mk.pop_back());
      end
   endtask

   task automatic checkAll(input string tag);
      int          occ;
      logic [31:0] exp_taps;
      occ = 0;
      foreach (mv[k]) if (mv[k]) occ++;
      for (int k = 0; k < DEPTH; k++) exp_taps[k*8 +: 8] = mdr[k];
      checkOutput({tag, ".valid_r"}, {31'd0, valid_r}, {31'd0, mv[DEPTH-1]});
      checkOutput({tag, ".count_r"}, {29'd0, count_r}, occ);
      checkOutput({tag, ".count_range"}, {31'd0, count_r <= 3'(DEPTH)}, 32'd1);
      checkOutput({tag, ".q_r"}, {24'd0, q_r}, {24'd0, mdr[DEPTH-1]});
      checkOutput({tag, ".taps_r"}, taps_r, exp_taps);
      checkOutput({tag, ".valid_n"}, {31'd0, valid_n}, {31'd0, mv[DEPTH-1]});
      checkOutput({tag, ".count_n"}, {29'd0, count_n}, occ);
      for (int k = 0; k < DEPTH; k++)
         if (mk[k]) checkOutput($sformatf("%s.tap_n%0d", tag, k), {24'd0, taps_n[k*8 +: 8]}, {24'd0, mdn[k]});
   endtask

   task automatic applyStimulus(input bit en, input bit fl, input bit v, input logic [7:0] d, input string tag);
      en_i = en; flush_i = fl; valid_i = v; d_i = d;
      @(posedge clk);
      modelStep(en, fl, v, d);
      #1;
      checkAll(tag);
   endtask

   // Asserts reset between edges, checks the immediate effect, holds it over one edge.
   task automatic asyncReset(input string tag);
      #2;
      reset = 1'b1;
      en_i = 1'b1; valid_i = 1'b1; d_i = 8'h5A;
      #1;
      modelReset();
      checkAll({tag, ".imm"});
      @(posedge clk);
      #1;
      checkAll({tag, ".held"});
      #2;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; en_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; d_i = 8'h00;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkAll("reset");
      #3 reset = 1'b0;

      // Latency and ordering
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 8'(i), $sformatf("lat%0d", i));
         if (i == 4) begin
            checkOutput("lat.first_q", {24'd0, q_r}, 32'h01);
            checkOutput("lat.first_valid", {31'd0, valid_r}, 32'd1);
         end
      end
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, "drain");

      // Stall with a full pipe
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h10, "fill");
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h20, "fill");
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h30, "fill");
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h40, "fill");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF, "stall");
      checkOutput("stall.taps", taps_r, 32'h10203040);
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h50, "resume");
      checkOutput("resume.q", {24'd0, q_r}, 32'h20);

      // Flush of a full pipe drops the incoming word
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h77, "flush");
      checkOutput("flush.taps", taps_r, 32'hA5A5A5A5);
      checkOutput("flush.count", {29'd0, count_r}, 32'd0);

      // Bubbles
      for (int i = 0; i < 8; i++)
         applyStimulus(1'b1, 1'b0, (i % 2) == 0, 8'(8'h11 * (i + 1)), "bubble");
      checkOutput("bubble.count", {29'd0, count_r}, 32'd2);

      // Mid-stream reset on a full pipe
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 8'(8'hC0 + i), "refill");
      asyncReset("rst_mid");
      checkOutput("rst_mid.taps", taps_r, 32'hA5A5A5A5);

      // Randomized traffic with occasional flush and reset
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) asyncReset("rnd_rst");
         else applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                            1'($urandom), 8'($urandom), "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/day44_dff_pipe.md
Name: day44_dff_pipe

Overview:
- Parametrised successor to the single-bit DFF block: a WIDTH-bit, DEPTH-stage register pipeline.
- Adds a per-stage valid bit, an advance enable (stall), a synchronous flush, and a live occupancy count.
- Data-register reset is selectable per instance, so one block provides both the "no reset" and "reset" flop flavours.
- Used as the generic delay/retiming element for datapaths in this codebase.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of pipeline stages (>=1).
- DATA_RST, 1, 1: data registers reset/flush to RST_VAL; 0: data registers have no reset (valid bits always reset).
- RST_VAL, 0, WIDTH-bit value loaded into data registers on reset/flush when DATA_RST=1.

Ports:
- clk  input  1  clock; all sequential logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- en_i  input  1  advance enable; 0 stalls (holds) every stage.
- flush_i  input  1  synchronous flush of all stages.
- valid_i  input  1  qualifies d_i.
- d_i  input  WIDTH  input data.
- q_o  output  WIDTH  last-stage data (stage DEPTH-1).
- valid_o  output  1  last-stage valid.
- taps_o  output  WIDTH*DEPTH  all stage data; stage k at bits [k*WIDTH +: WIDTH].
- count_o  output  $clog2(DEPTH+1)  number of stages holding valid data.

Behaviour:
- Reset: one clock, clk. reset is asynchronous and active-high. Assertion takes effect immediately, without waiting for a clock edge.
  - All valid bits go to 0; valid_o=0; count_o=0.
  - DATA_RST=1: every stage, and therefore q_o and taps_o, goes to RST_VAL.
  - DATA_RST=0: data registers are not reset. q_o/taps_o are unspecified until written, and the bench must not check them.
  - While reset is high, all other inputs are ignored.
  - First capture is on the first posedge after reset falls.
- Priority at each posedge: reset > flush_i > en_i > hold.
- flush_i=1 (regardless of en_i):
  - All valid bits clear; count_o becomes 0 next cycle.
  - The incoming valid_i/d_i is dropped.
  - Data goes to RST_VAL if DATA_RST=1; otherwise data holds.
- en_i=1, flush_i=0:
  - stage0 <= d_i, valid0 <= valid_i.
  - stage k <= stage k-1 and valid k <= valid k-1, for k=1..DEPTH-1.
  - Data shifts even when valid_i=0 (bubbles carry data but valid=0).
- en_i=0, flush_i=0: all data, valid bits and count_o hold.
- Latency: a word presented with valid_i=1 appears on q_o/valid_o after exactly DEPTH posedges with en_i=1. Stalled cycles add latency 1:1.
- count_o:
  - Registered counter; next value = count + valid_i - valid_o when advancing, otherwise unchanged.
  - Must equal the popcount of the stage valid bits on every cycle.
  - Range is 0..DEPTH. No wrap can occur; any value outside 0..DEPTH is a bench error.
  - Simultaneous entry (valid_i=1) and exit (valid_o=1) leaves the count unchanged.
- All outputs are driven directly from registers; there is no combinational input-to-output path.
- Reset asserted mid-stream aborts in-flight data immediately, with no partial shift.

Test Plan:
(WIDTH=8, DEPTH=4, DATA_RST=1, RST_VAL=8'hA5 unless noted)
- Reset: assert reset mid-cycle (off clock edge) while the pipe is full -> valid_o=0, count_o=0 and all taps=8'hA5 immediately, before the next posedge.
- Latency/order: en_i=1; feed valid 8'h01,02,03,04,05 on consecutive cycles -> q_o=8'h01 with valid_o=1 at the 4th posedge after the first input, then 02..05 on consecutive cycles; count_o ramps 1,2,3,4 and holds at 4.
- Stall: pipe full with 10,20,30,40; en_i=0 for 3 cycles with valid_i=1, d_i=8'hFF -> all taps, valid_o and count_o frozen; 8'hFF not captured; resuming shifts normally.
- Bubbles: alternate valid_i 1/0 with d_i=8'h11,8'h22,... -> valid_o pattern 1,0,1,0 after 4 cycles; count_o settles at 2.
- Flush: full pipe, flush_i=1 with en_i=1 and valid_i=1, d_i=8'h77 -> next cycle count_o=0, valid_o=0, taps=8'hA5, and 8'h77 is dropped.
- DATA_RST=0 build: reset -> only valid_o/count_o checked as 0; after 4 valid inputs q_o matches the first input; flush holds data and clears the valids.
